// File: rtl/xa_bf_dir_vec_ser_if.sv
// xa_bf_dir_vec_ser_if: X/Y/Z direction-vector word stream with valid/ready handshake
interface xa_bf_dir_vec_ser_if;
   logic        valid;
   logic [31:0] data;
   logic [1:0]  sel;
   logic [9:0]  beam_idx;
   logic        last;
   logic        ready;
   modport master (output valid, data, sel, beam_idx, last, input ready);
   modport slave  (input valid, data, sel, beam_idx, last, output ready);
endinterface

// File: rtl/xa_bf_dir_vec_ser.sv
// xa_bf_dir_vec_ser: buffers beam direction-vector sets and replays each as an X/Y/Z word stream
module xa_bf_dir_vec_ser #(
   parameter int P_DEPTH = 4,
   parameter int P_AW    = 2
) (
   input  logic                i_clk156m,
   input  logic                i_srst,
   input  logic                i_bm_start,
   input  logic [9:0]          i_beam_idx,
   input  logic [31:0]         i_dir_ss_x,
   input  logic [31:0]         i_dir_ss_y,
   input  logic [31:0]         i_dir_ss_z,
   input  logic                i_ovf_clr,
   xa_bf_dir_vec_ser_if.master o_vec,
   output logic [P_AW:0]       o_fifo_cnt,
   output logic                o_ovf
);
   typedef struct packed {
      logic [9:0]  idx;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] z;
   } ent_t;
   typedef enum logic [1:0] {IDLE, SEND_X, SEND_Y, SEND_Z} st_t;
   localparam logic [P_AW:0] L_FULL = (P_AW+1)'(P_DEPTH);
   localparam logic [P_AW:0] L_ONE  = (P_AW+1)'(1);
   ent_t            r_mem [P_DEPTH];
   ent_t            r_ent;
   st_t             r_st;
   logic [P_AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [P_AW:0]   r_cnt;
   logic            r_valid, r_last, r_ovf;
   logic [1:0]      r_sel;
   logic [31:0]     r_data;
   ent_t            w_in, w_head, w_nxt_ent;
   st_t             w_nxt;
   logic            w_hs, w_pop, w_push, w_load;
   logic [P_AW:0]   w_cnt_nx;
   always_comb begin
      w_in      = {i_beam_idx, i_dir_ss_x, i_dir_ss_y, i_dir_ss_z};
      w_hs      = r_valid & o_vec.ready;
      w_pop     = w_hs & r_last;
      w_push    = i_bm_start & ((r_cnt != L_FULL) | w_pop);
      w_cnt_nx  = r_cnt + (P_AW+1)'(w_push) - (P_AW+1)'(w_pop);
      w_head    = !w_pop ? r_mem[r_rd_ptr] : (r_cnt == L_ONE) ? w_in : r_mem[r_rd_ptr + P_AW'(1)];
      w_load    = (r_st == IDLE && r_cnt != '0) || (w_pop && w_cnt_nx != '0);
      w_nxt_ent = w_load ? w_head : r_ent;
      w_nxt     = w_load ? SEND_X :
                  (r_st == IDLE || !w_hs) ? r_st :
                  (r_st == SEND_X) ? SEND_Y :
                  (r_st == SEND_Y) ? SEND_Z : IDLE;
   end
   always_ff @(posedge i_clk156m) begin
      if (i_srst) begin
         r_st     <= IDLE;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
         r_ovf    <= 1'b0;
         r_ent    <= '0;
         r_valid  <= 1'b0;
         r_sel    <= 2'd0;
         r_last   <= 1'b0;
         r_data   <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_in;
            r_wr_ptr        <= r_wr_ptr + P_AW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + P_AW'(1);
         r_cnt   <= w_cnt_nx;
         r_ovf   <= (i_bm_start & ~w_push) | (r_ovf & ~i_ovf_clr);
         r_st    <= w_nxt;
         r_ent   <= w_nxt_ent;
         r_valid <= w_nxt != IDLE;
         r_sel   <= (w_nxt == SEND_Y) ? 2'd1 : (w_nxt == SEND_Z) ? 2'd2 : 2'd0;
         r_last  <= w_nxt == SEND_Z;
         r_data  <= (w_nxt == SEND_Y) ? w_nxt_ent.y : (w_nxt == SEND_Z) ? w_nxt_ent.z : w_nxt_ent.x;
      end
   end
   assign o_vec.valid    = r_valid;
   assign o_vec.data     = r_data;
   assign o_vec.sel      = r_sel;
   assign o_vec.beam_idx = r_ent.idx;
   assign o_vec.last     = r_last;
   assign o_fifo_cnt     = r_cnt;
   assign o_ovf          = r_ovf;
endmodule

// File: tb/tb_xa_bf_dir_vec_ser.sv
// tb_xa_bf_dir_vec_ser: directed and random stimulus against a queue-based reference model
module tb_xa_bf_dir_vec_ser;
   typedef struct {
      logic [9:0]  idx;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] z;
   } ent_t;
   logic        clk = 1'b0;
   logic        srst = 1'b1, start = 1'b0, clr = 1'b0, rdy = 1'b0;
   logic [9:0]  idx = '0;
   logic [31:0] dx = '0, dy = '0, dz = '0;
   logic [2:0]  cnt;
   logic        ovf;
   ent_t        q[$];
   bit          m_busy, m_ovf;
   int          m_w;
   int          n_asrt, n_fail;
   always #5 clk = ~clk;
   xa_bf_dir_vec_ser_if vec();
   assign vec.ready = rdy;
   xa_bf_dir_vec_ser dut (
      .i_clk156m (clk),
      .i_srst    (srst),
      .i_bm_start(start),
      .i_beam_idx(idx),
      .i_dir_ss_x(dx),
      .i_dir_ss_y(dy),
      .i_dir_ss_z(dz),
      .i_ovf_clr (clr),
      .o_vec     (vec),
      .o_fifo_cnt(cnt),
      .o_ovf     (ovf)
   );
   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_asrt++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] word(ent_t e, int w);
      return (w == 0) ? e.x : (w == 1) ? e.y : e.z;
   endfunction
   task automatic check_all();
      chk("valid", 32'(vec.valid), 32'(m_busy));
      chk("cnt", 32'(cnt), q.size());
      chk("ovf", 32'(ovf), 32'(m_ovf));
      if (m_busy) begin
         chk("data", vec.data, word(q[0], m_w));
         chk("sel", 32'(vec.sel), m_w);
         chk("beam_idx", 32'(vec.beam_idx), 32'(q[0].idx));
         chk("last", 32'(vec.last), 32'(m_w == 2));
      end
   endtask
   task automatic model();
      bit   hs, pop, push;
      int   sz0;
      ent_t e;
      if (srst) begin
         q.delete();
         m_busy = 0;
         m_w    = 0;
         m_ovf  = 0;
      end else begin
         hs   = m_busy && rdy;
         pop  = hs && m_w == 2;
         push = start && (q.size() < 4 || pop);
         sz0  = q.size();
         m_ovf = (start && !push) || (m_ovf && !clr);
         e.idx = idx; e.x = dx; e.y = dy; e.z = dz;
         if (pop) void'(q.pop_front());
         if (push) q.push_back(e);
         if (!m_busy) begin
            if (sz0 != 0) begin
               m_busy = 1;
               m_w    = 0;
            end
         end else if (hs) begin
            if (m_w < 2) m_w++;
            else if (q.size() != 0) m_w = 0;
            else m_busy = 0;
         end
      end
   endtask
   task automatic cyc();
      @(negedge clk);
      check_all();
      @(posedge clk);
      model();
      #1;
   endtask
   task automatic pulse(logic [9:0] i);
      start = 1'b1;
      idx   = i;
      dx    = $urandom;
      dy    = $urandom;
      dz    = $urandom;
      cyc();
      start = 1'b0;
   endtask
   initial begin
      int         k, nv;
      logic [9:0] last_idx;
      repeat (2) begin
         @(posedge clk);
         model();
      end
      #1;
      srst = 1'b0;
      chk("reset_valid", 32'(vec.valid), 32'd0);
      chk("reset_cnt", 32'(cnt), 32'd0);
      chk("reset_ovf", 32'(ovf), 32'd0);
      cyc();
      // single set, consumer always ready
      rdy = 1'b1; start = 1'b1; idx = 10'd5;
      dx = 32'h3F800000; dy = 32'hBF800000; dz = 32'h40000000;
      cyc();
      start = 1'b0;
      cyc();
      chk("t1_valid_T2", 32'(vec.valid), 32'd1);
      chk("t1_x", vec.data, 32'h3F800000);
      cyc();
      chk("t1_y_sel", 32'(vec.sel), 32'd1);
      cyc();
      chk("t1_z", vec.data, 32'h40000000);
      chk("t1_last_T4", 32'(vec.last), 32'd1);
      cyc();
      chk("t1_idle_valid", 32'(vec.valid), 32'd0);
      chk("t1_cnt", 32'(cnt), 32'd0);
      // stall on the Y word
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      cyc();
      rdy = 1'b0;
      repeat (5) begin
         chk("t2_hold_y", vec.data, 32'hBF800000);
         chk("t2_hold_sel", 32'(vec.sel), 32'd1);
         cyc();
      end
      rdy = 1'b1;
      cyc();
      chk("t2_z_after_ready", 32'(vec.sel), 32'd2);
      cyc();
      cyc();
      // burst of four while stalled, then back-to-back drain
      rdy = 1'b0;
      repeat (4) begin
         pulse(10'($urandom));
         cyc();
         cyc();
      end
      chk("t3_cnt_full", 32'(cnt), 32'd4);
      chk("t3_no_ovf", 32'(ovf), 32'd0);
      rdy = 1'b1;
      nv = 0;
      repeat (12) begin
         if (vec.valid === 1'b1) nv++;
         cyc();
      end
      chk("t3_no_gap", nv, 32'd12);
      chk("t3_cnt_empty", 32'(cnt), 32'd0);
      cyc();
      // overflow and clear priority
      rdy = 1'b0;
      repeat (4) pulse(10'($urandom));
      cyc();
      pulse(10'd9);
      chk("t4_ovf_set", 32'(ovf), 32'd1);
      chk("t4_cnt_kept", 32'(cnt), 32'd4);
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      chk("t4_ovf_clr", 32'(ovf), 32'd0);
      clr = 1'b1;
      pulse(10'd9);
      clr = 1'b0;
      chk("t4_set_wins", 32'(ovf), 32'd1);
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      // capture coinciding with the Z-word pop while full
      rdy = 1'b1;
      k = 0;
      while (vec.sel !== 2'd2 && k < 10) begin
         cyc();
         k++;
      end
      chk("t5_reach_z", 32'(vec.sel), 32'd2);
      pulse(10'h3AB);
      chk("t5_cnt_stays", 32'(cnt), 32'd4);
      chk("t5_no_ovf", 32'(ovf), 32'd0);
      last_idx = '0;
      k = 0;
      while (cnt !== 3'd0 && k < 40) begin
         if (vec.valid === 1'b1 && vec.last === 1'b1) last_idx = vec.beam_idx;
         cyc();
         k++;
      end
      chk("t5_drained", 32'(cnt), 32'd0);
      chk("t5_last_idx", 32'(last_idx), 32'h3AB);
      // reset mid-transfer
      rdy = 1'b0;
      repeat (3) pulse(10'($urandom));
      cyc();
      rdy = 1'b1;
      cyc();
      rdy = 1'b0;
      chk("t6_sel_y", 32'(vec.sel), 32'd1);
      chk("t6_cnt3", 32'(cnt), 32'd3);
      srst = 1'b1;
      cyc();
      srst = 1'b0;
      chk("t6_valid_cleared", 32'(vec.valid), 32'd0);
      chk("t6_cnt_cleared", 32'(cnt), 32'd0);
      pulse(10'($urandom));
      rdy = 1'b1;
      repeat (6) cyc();
      chk("t6_restream_done", 32'(cnt), 32'd0);
      // random traffic
      repeat (600) begin
         start = ($urandom_range(0, 2) == 0);
         idx   = 10'($urandom);
         dx    = $urandom;
         dy    = $urandom;
         dz    = $urandom;
         rdy   = ($urandom_range(0, 2) != 0);
         clr   = ($urandom_range(0, 19) == 0);
         srst  = ($urandom_range(0, 199) == 0);
         cyc();
      end
      start = 1'b0;
      clr   = 1'b0;
      srst  = 1'b0;
      rdy   = 1'b1;
      repeat (20) cyc();
      chk("final_cnt", 32'(cnt), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
